master_port: RTL and testbench

MASTER_PORT -- requirements
Module: master_port

---
 rtl/master_port.sv | 243 ++++++++++++++++++++++++
 tb/tb_master_port.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/master_port.sv
`default_nettype none
// ============================================================================
// Module   : master_port
// Purpose  : Serial bus master. Accepts a single-beat read/write request,
//            handshakes with the slave, shifts address/write data out LSB
//            first, shifts read data in LSB first, and reports completion
//            with a one-cycle response pulse. Both handshake waits are
//            bounded by a timeout that completes the transfer with an error.
// Revision : 1.0  initial release
// ============================================================================
module master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    // user request / response
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // serial bus towards the slave
    output logic                  read_en,
    output logic                  write_en,
    output logic                  master_valid,
    output logic                  master_ready,
    input  logic                  slave_ready,
    input  logic                  slave_valid,
    output logic                  tx_addr,
    output logic                  tx_data,
    output logic                  tx_burst,
    input  logic                  rx_data
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_max_w = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int c_cnt_w = $clog2(c_max_w) + 1;

    localparam logic [c_cnt_w-1:0] c_addr_last = c_cnt_w'(ADDR_WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_data_last = c_cnt_w'(DATA_WIDTH - 1);
    // The wait counter starts at 0 on entry, so the last waiting cycle is TIMEOUT-1
    localparam logic [7:0]         c_to_last   = 8'(TIMEOUT - 1);

    localparam logic [2:0] c_s_idle     = 3'd0;
    localparam logic [2:0] c_s_wait_slv = 3'd1;
    localparam logic [2:0] c_s_addr     = 3'd2;
    localparam logic [2:0] c_s_wdata    = 3'd3;
    localparam logic [2:0] c_s_rwait    = 3'd4;
    localparam logic [2:0] c_s_rdata    = 3'd5;
    localparam logic [2:0] c_s_done     = 3'd6;

    // ------------------------------------------------------------------
    // State, counters and shadow registers
    // ------------------------------------------------------------------
    logic [2:0]            r_state,   w_state_n;
    logic [c_cnt_w-1:0]    r_bit_cnt, w_bit_cnt_n;
    logic [7:0]            r_to_cnt,  w_to_cnt_n;
    logic                  r_wr,      w_wr_n;
    logic [ADDR_WIDTH-1:0] r_addr,    w_addr_n;
    logic [DATA_WIDTH-1:0] r_wdata,   w_wdata_n;
    logic [DATA_WIDTH-1:0] r_rdata,   w_rdata_n;
    logic                  w_err_n;

    // Next values of the registered outputs
    logic                  w_req_ready_d;
    logic                  w_rsp_valid_d;
    logic [DATA_WIDTH-1:0] w_rsp_rdata_d;
    logic                  w_rsp_err_d;
    logic                  w_read_en_d;
    logic                  w_write_en_d;
    logic                  w_master_valid_d;
    logic                  w_master_ready_d;
    logic                  w_tx_addr_d;
    logic                  w_tx_data_d;
    logic                  w_busy_n;

    // Single-beat transfers only
    assign tx_burst = 1'b0;

    // State register plus the counters and shift registers it sequences
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_s_idle;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_n;
            r_bit_cnt <= w_bit_cnt_n;
            r_to_cnt  <= w_to_cnt_n;
            r_wr      <= w_wr_n;
            r_addr    <= w_addr_n;
            r_wdata   <= w_wdata_n;
            r_rdata   <= w_rdata_n;
        end
    end

    // Next-state logic; address and write data shift right so bit 0 is always the bit on the wire
    always_comb begin
        w_state_n   = r_state;
        w_bit_cnt_n = r_bit_cnt;
        w_to_cnt_n  = r_to_cnt;
        w_wr_n      = r_wr;
        w_addr_n    = r_addr;
        w_wdata_n   = r_wdata;
        w_rdata_n   = r_rdata;
        w_err_n     = 1'b0;

        case (r_state)
            c_s_idle: begin
                if (req_valid) begin
                    w_state_n   = c_s_wait_slv;
                    w_wr_n      = req_write;
                    w_addr_n    = req_addr;
                    w_wdata_n   = req_wdata;
                    w_rdata_n   = '0;
                    w_bit_cnt_n = '0;
                    w_to_cnt_n  = '0;
                end
            end

            c_s_wait_slv: begin
                // A handshake in the timeout cycle still wins
                if (slave_ready) begin
                    w_state_n   = c_s_addr;
                    w_bit_cnt_n = '0;
                end else if (r_to_cnt == c_to_last) begin
                    w_state_n = c_s_done;
                    w_err_n   = 1'b1;
                end else begin
                    w_to_cnt_n = r_to_cnt + 8'd1;
                end
            end

            c_s_addr: begin
                if (r_bit_cnt == c_addr_last) begin
                    w_bit_cnt_n = '0;
                    w_to_cnt_n  = '0;
                    w_state_n   = r_wr ? c_s_wdata : c_s_rwait;
                end else begin
                    w_bit_cnt_n = r_bit_cnt + 1'b1;
                    w_addr_n    = r_addr >> 1;
                end
            end

            c_s_wdata: begin
                if (r_bit_cnt == c_data_last) begin
                    w_state_n = c_s_done;
                end else begin
                    w_bit_cnt_n = r_bit_cnt + 1'b1;
                    w_wdata_n   = r_wdata >> 1;
                end
            end

            c_s_rwait: begin
                if (slave_valid) begin
                    w_state_n   = c_s_rdata;
                    w_bit_cnt_n = '0;
                end else if (r_to_cnt == c_to_last) begin
                    w_state_n = c_s_done;
                    w_err_n   = 1'b1;
                end else begin
                    w_to_cnt_n = r_to_cnt + 8'd1;
                end
            end

            c_s_rdata: begin
                // Shift in from the top so the first received bit ends up in bit 0
                w_rdata_n = {rx_data, r_rdata[DATA_WIDTH-1:1]};
                if (r_bit_cnt == c_data_last) begin
                    w_state_n = c_s_done;
                end else begin
                    w_bit_cnt_n = r_bit_cnt + 1'b1;
                end
            end

            c_s_done: begin
                w_state_n = c_s_idle;
            end

            default: begin
                w_state_n = c_s_idle;
            end
        endcase
    end

    // Output decode from the next state so registered outputs line up with the state they describe
    always_comb begin
        w_busy_n = (w_state_n == c_s_wait_slv) || (w_state_n == c_s_addr)  ||
                   (w_state_n == c_s_wdata)    || (w_state_n == c_s_rwait) ||
                   (w_state_n == c_s_rdata);

        w_req_ready_d    = (w_state_n == c_s_idle);
        w_rsp_valid_d    = (w_state_n == c_s_done);
        w_rsp_err_d      = w_err_n;
        w_rsp_rdata_d    = ((w_state_n == c_s_done) && !w_err_n) ? w_rdata_n : '0;
        w_write_en_d     = w_busy_n &&  w_wr_n;
        w_read_en_d      = w_busy_n && !w_wr_n;
        w_master_valid_d = (w_state_n == c_s_addr)  || (w_state_n == c_s_wdata);
        w_master_ready_d = (w_state_n == c_s_rwait) || (w_state_n == c_s_rdata);
        w_tx_addr_d      = (w_state_n == c_s_addr)  ? w_addr_n[0]  : 1'b0;
        w_tx_data_d      = (w_state_n == c_s_wdata) ? w_wdata_n[0] : 1'b0;
    end

    // Output registers; reset clears the bus lines immediately, leaving only req_ready high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            read_en      <= 1'b0;
            write_en     <= 1'b0;
            master_valid <= 1'b0;
            master_ready <= 1'b0;
            tx_addr      <= 1'b0;
            tx_data      <= 1'b0;
        end else begin
            req_ready    <= w_req_ready_d;
            rsp_valid    <= w_rsp_valid_d;
            rsp_rdata    <= w_rsp_rdata_d;
            rsp_err      <= w_rsp_err_d;
            read_en      <= w_read_en_d;
            write_en     <= w_write_en_d;
            master_valid <= w_master_valid_d;
            master_ready <= w_master_ready_d;
            tx_addr      <= w_tx_addr_d;
            tx_data      <= w_tx_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_master_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_master_port
// Purpose  : Directed self-checking bench for master_port. Cycle n is the
//            clock period that follows accept edge + (n-1); outputs are
//            sampled on the falling edge. Output bus packing (18 bits):
//            {req_ready, rsp_valid, rsp_err, read_en, write_en,
//             master_valid, master_ready, tx_addr, tx_data, tx_burst,
//             rsp_rdata[7:0]}
// Revision : 1.0  initial release
// ============================================================================
module tb_master_port;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [11:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       read_en;
    logic       write_en;
    logic       master_valid;
    logic       master_ready;
    logic       slave_ready = 1'b0;
    logic       slave_valid = 1'b0;
    logic       tx_addr;
    logic       tx_data;
    logic       tx_burst;
    logic       rx_data = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    master_port #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (8),
        .TIMEOUT    (255)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .read_en      (read_en),
        .write_en     (write_en),
        .master_valid (master_valid),
        .master_ready (master_ready),
        .slave_ready  (slave_ready),
        .slave_valid  (slave_valid),
        .tx_addr      (tx_addr),
        .tx_data      (tx_data),
        .tx_burst     (tx_burst),
        .rx_data      (rx_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] bus_now();
        return {req_ready, rsp_valid, rsp_err, read_en, write_en, master_valid,
                master_ready, tx_addr, tx_data, tx_burst, rsp_rdata};
    endfunction

    // Expected output bus in cycle c of a transfer with immediate slave handshakes
    function automatic logic [17:0] exp_bus(input logic wr, input logic [11:0] addr,
                                            input logic [7:0] wd, input logic [7:0] rd,
                                            input int c);
        logic [17:0] e;
        logic [11:0] a_sh;
        logic [7:0]  d_sh;
        int          done;
        done = wr ? 22 : 23;
        e    = '0;
        if (c == done) begin
            e[16] = 1'b1;
            if (!wr) e[7:0] = rd;
        end
        if (!wr && c >= 1 && c <= 22) e[14] = 1'b1;
        if ( wr && c >= 1 && c <= 21) e[13] = 1'b1;
        if (c >= 2 && c <= 13) begin
            e[12] = 1'b1;
            a_sh  = addr >> (c - 2);
            e[10] = a_sh[0];
        end
        if (wr && c >= 14 && c <= 21) begin
            e[12] = 1'b1;
            d_sh  = wd >> (c - 14);
            e[9]  = d_sh[0];
        end
        if (!wr && c >= 14 && c <= 22) e[11] = 1'b1;
        return e;
    endfunction

    // Full transfer with immediate handshakes; starts and ends on a falling edge with the DUT idle
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [7:0] wd,
                        input logic [7:0] rd, input logic keep_valid, input string name);
        int         done;
        logic [7:0] rd_sh;
        done  = wr ? 22 : 23;
        rd_sh = rd;
        check_val($sformatf("%s ready", name), {31'd0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        req_write   = wr;
        req_addr    = addr;
        req_wdata   = wd;
        slave_ready = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Scramble the request after accept; the transfer must not notice
                req_valid = keep_valid;
                req_write = ~wr;
                req_addr  = ~addr;
                req_wdata = ~wd;
            end
            slave_valid = (!wr && c == 14);
            if (c >= 15 && c <= 22) begin
                rx_data = rd_sh[0];
                rd_sh   = rd_sh >> 1;
            end else begin
                rx_data = 1'b0;
            end
            check_val($sformatf("%s c%0d", name, c), {14'd0, bus_now()},
                      {14'd0, exp_bus(wr, addr, wd, rd, c)});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Transfer that ends in a timeout; checks the completion cycle and the error response
    task automatic run_timeout(input logic wr, input logic srdy, input int sv_pulse,
                               input int exp_cyc, input logic [17:0] exp_pre, input string name);
        int   c;
        logic seen;
        req_valid   = 1'b1;
        req_write   = wr;
        req_addr    = 12'h0F0;
        req_wdata   = 8'hFF;
        slave_ready = srdy;
        slave_valid = 1'b0;
        rx_data     = 1'b1;
        @(posedge clk);
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 400) begin
            @(negedge clk);
            c++;
            if (c == 1) req_valid = 1'b0;
            slave_valid = (c == sv_pulse);
            if (rsp_valid) seen = 1'b1;
            else if (c == exp_cyc - 1)
                check_val({name, " pre"}, {14'd0, bus_now()}, {14'd0, exp_pre});
        end
        check_val({name, " rsp cycle"}, c, exp_cyc);
        check_val({name, " rsp bus"}, {14'd0, bus_now()}, {14'd0, 18'h18000});
        @(negedge clk);
        check_val({name, " idle"}, {14'd0, bus_now()}, {14'd0, 18'h20000});
        rx_data     = 1'b0;
        slave_valid = 1'b0;
    endtask

    initial begin
        int n_rsp;

        // Asynchronous reset state, before any clock edge
        #1 reset = 1'b1;
        #2 check_val("reset state", {14'd0, bus_now()}, {14'd0, 18'h20000});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Write 0xABC / 0x5A
        xfer(1'b1, 12'hABC, 8'h5A, 8'h00, 1'b0, "wr_abc");
        // Read 0x001 returning 0x3C
        xfer(1'b0, 12'h001, 8'h00, 8'h3C, 1'b0, "rd_001");
        // Back-to-back write then read with req_valid held high
        xfer(1'b1, 12'h123, 8'hC3, 8'h00, 1'b1, "b2b_wr");
        xfer(1'b0, 12'h7FE, 8'h00, 8'hA5, 1'b0, "b2b_rd");

        // slave_ready held low: timeout out of WAIT_SLV, write_en high until then
        run_timeout(1'b1, 1'b0, 0, 256, 18'h02000, "to_wait_slv");
        // slave_valid pulsed during ADDR only: timeout out of RWAIT
        run_timeout(1'b0, 1'b1, 5, 269, 18'h04800, "to_rwait");

        // Reset during ADDR cycle 5
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_addr    = 12'h3C3;
        req_wdata   = 8'h99;
        slave_ready = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
        end
        check_val("rst pre c5", {14'd0, bus_now()}, {14'd0, exp_bus(1'b1, 12'h3C3, 8'h99, 8'h00, 5)});
        #2 reset = 1'b1;
        #1 check_val("rst async", {14'd0, bus_now()}, {14'd0, 18'h20000});
        @(negedge clk);
        reset = 1'b0;
        n_rsp = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        check_val("rst no rsp", n_rsp, 0);
        xfer(1'b1, 12'h555, 8'h81, 8'h00, 1'b0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
